// File: rtl/riscv_tag_violation_handler.sv
// ----------------------------------------------------------------------------
// riscv_tag_violation_handler
//
// EX-stage DIFT tag violation handler. Combines the per-operand check enables
// from the ID-stage check decoder with the operand/PC tags. A violation
// latches PC, instruction word and a cause mask, and raises an exception
// request to the controller. EX stays stalled until the controller
// acknowledges and a short drain window has elapsed. A saturating counter
// tallies every violation, including those that arrive while an earlier one
// is still being handled.
//
// Parameters
//   CNT_W        width of the saturating violation counter
//   DRAIN_CYCLES number of DRAIN cycles after ack (flush window), >= 1
//
// Ports
//   clk, rst           core clock, synchronous active-high reset
//   enable_i           global enforcement enable
//   ex_valid_i         EX holds a valid instruction
//   ex_ready_i         EX instruction completes this cycle
//   check_*_i          per-operand check enables (s1, s2, d, pc)
//   tag_*_i            per-operand tags (s1, s2, d, pc)
//   pc_ex_i            PC of the EX instruction
//   instr_ex_i         instruction word in EX
//   exc_ack_i          controller accepts the exception
//   clr_i              software clear of log and counter
//   exc_req_o          exception request to controller
//   halt_ex_o          stall EX while not idle
//   exc_cause_o        {pc,d,s2,s1} violation mask of the logged event
//   viol_pc_o          PC of the logged violation
//   viol_instr_o       instruction of the logged violation
//   viol_cnt_o         saturating violation count
// ----------------------------------------------------------------------------
module riscv_tag_violation_handler #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             ex_valid_i,
    input  logic             ex_ready_i,
    input  logic             check_s1_i,
    input  logic             check_s2_i,
    input  logic             check_d_i,
    input  logic             check_pc_i,
    input  logic             tag_s1_i,
    input  logic             tag_s2_i,
    input  logic             tag_d_i,
    input  logic             tag_pc_i,
    input  logic [31:0]      pc_ex_i,
    input  logic [31:0]      instr_ex_i,
    input  logic             exc_ack_i,
    input  logic             clr_i,
    output logic             exc_req_o,
    output logic             halt_ex_o,
    output logic [3:0]       exc_cause_o,
    output logic [31:0]      viol_pc_o,
    output logic [31:0]      viol_instr_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int              DW         = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [3:0] check_vec;
    logic [3:0] tag_vec;
    logic [3:0] viol_mask;
    logic       hit;

    logic [1:0]       state_reg, state_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic             req_reg, halt_reg;
    logic [3:0]       cause_reg, cause_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      instr_reg, instr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             log_en;

    assign check_vec = {check_pc_i, check_d_i, check_s2_i, check_s1_i};
    assign tag_vec   = {tag_pc_i, tag_d_i, tag_s2_i, tag_s1_i};

    // Bit order of the mask matches exc_cause_o: {pc, d, s2, s1}.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign viol_mask[gi] = check_vec[gi] & tag_vec[gi];
    end

    // Only instructions that actually retire from EX can violate.
    assign hit = enable_i & ex_valid_i & ex_ready_i & (|viol_mask);

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_IDLE: begin
                if (hit) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (exc_ack_i) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    drain_next = drain_reg - DW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The log belongs to the event being handled: later hits only count.
    // A hit in IDLE takes priority over a simultaneous software clear.
    assign log_en = hit && (state_reg == ST_IDLE);

    always_comb begin
        cause_next = cause_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        if (log_en) begin
            cause_next = viol_mask;
            pc_next    = pc_ex_i;
            instr_next = instr_ex_i;
        end else if (clr_i) begin
            cause_next = '0;
            pc_next    = '0;
            instr_next = '0;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
            cnt_next = {{(CNT_W-1){1'b0}}, hit};
        end else if (hit && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            drain_reg <= '0;
            req_reg   <= 1'b0;
            halt_reg  <= 1'b0;
            cause_reg <= '0;
            pc_reg    <= '0;
            instr_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            req_reg   <= (state_next == ST_REQ);
            halt_reg  <= (state_next != ST_IDLE);
            cause_reg <= cause_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign exc_req_o    = req_reg;
    assign halt_ex_o    = halt_reg;
    assign exc_cause_o  = cause_reg;
    assign viol_pc_o    = pc_reg;
    assign viol_instr_o = instr_reg;
    assign viol_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_riscv_tag_violation_handler.sv
// ----------------------------------------------------------------------------
// tb_riscv_tag_violation_handler
//
// Directed bench for riscv_tag_violation_handler (CNT_W=4, DRAIN_CYCLES=2).
// Stimulus pushes the expected output snapshot for a given cycle into a
// queue; an independent monitor samples the DUT on the falling edge and
// compares against the queue entry due in that cycle.
// ----------------------------------------------------------------------------
module tb_riscv_tag_violation_handler;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, ex_valid_i, ex_ready_i;
    logic        check_s1_i, check_s2_i, check_d_i, check_pc_i;
    logic        tag_s1_i, tag_s2_i, tag_d_i, tag_pc_i;
    logic [31:0] pc_ex_i, instr_ex_i;
    logic        exc_ack_i, clr_i;
    logic        exc_req_o, halt_ex_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] viol_pc_o, viol_instr_o;
    logic [CNT_W-1:0] viol_cnt_o;

    riscv_tag_violation_handler #(.CNT_W(CNT_W), .DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_i   (ex_ready_i),
        .check_s1_i   (check_s1_i),
        .check_s2_i   (check_s2_i),
        .check_d_i    (check_d_i),
        .check_pc_i   (check_pc_i),
        .tag_s1_i     (tag_s1_i),
        .tag_s2_i     (tag_s2_i),
        .tag_d_i      (tag_d_i),
        .tag_pc_i     (tag_pc_i),
        .pc_ex_i      (pc_ex_i),
        .instr_ex_i   (instr_ex_i),
        .exc_ack_i    (exc_ack_i),
        .clr_i        (clr_i),
        .exc_req_o    (exc_req_o),
        .halt_ex_o    (halt_ex_o),
        .exc_cause_o  (exc_cause_o),
        .viol_pc_o    (viol_pc_o),
        .viol_instr_o (viol_instr_o),
        .viol_cnt_o   (viol_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        req;
        logic        halt;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (exc_req_o !== e.req || halt_ex_o !== e.halt || exc_cause_o !== e.cause ||
                         viol_pc_o !== e.pc || viol_instr_o !== e.instr || viol_cnt_o !== e.cnt) begin
                errors++;
                $display("FAIL %s cyc %0d: got req=%b halt=%b cause=%b pc=%h instr=%h cnt=%0d, expected req=%b halt=%b cause=%b pc=%h instr=%h cnt=%0d",
                         e.name, cyc, exc_req_o, halt_ex_o, exc_cause_o, viol_pc_o, viol_instr_o, viol_cnt_o,
                         e.req, e.halt, e.cause, e.pc, e.instr, e.cnt);
            end else begin
                $display("check %s cyc %0d: req=%b halt=%b cause=%b pc=%h instr=%h cnt=%0d ok",
                         e.name, cyc, exc_req_o, halt_ex_o, exc_cause_o, viol_pc_o, viol_instr_o, viol_cnt_o);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input string name, input logic req, input logic halt,
                             input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] instr,
                             input int cnt);
        exp_t e;
        e.cyc   = cyc + dly;
        e.name  = name;
        e.req   = req;
        e.halt  = halt;
        e.cause = cause;
        e.pc    = pc;
        e.instr = instr;
        e.cnt   = CNT_W'(cnt);
        exp_q.push_back(e);
    endtask

    // chk/tag bit order {pc, d, s2, s1}
    task automatic drive(input logic en, input logic vld, input logic rdy, input logic [3:0] chk,
                         input logic [3:0] tag, input logic [31:0] pc, input logic [31:0] instr);
        enable_i   = en;
        ex_valid_i = vld;
        ex_ready_i = rdy;
        {check_pc_i, check_d_i, check_s2_i, check_s1_i} = chk;
        {tag_pc_i, tag_d_i, tag_s2_i, tag_s1_i}         = tag;
        pc_ex_i    = pc;
        instr_ex_i = instr;
    endtask

    task automatic idle_inputs();
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        exc_ack_i = 1'b0;
        clr_i = 1'b0;
        idle_inputs();
        step();
        step();
        expect_at(0, "reset", 0, 0, 4'b0000, 32'h0, 32'h0, 0);
        rst = 1'b0;

        // first violation on rs1
        drive(1, 1, 1, 4'b0001, 4'b0001, 32'h100, 32'h00B50533);
        expect_at(1, "t1_req", 1, 1, 4'b0001, 32'h100, 32'h00B50533, 1);
        step();
        idle_inputs();

        // second hit during REQ: log kept, count grows
        drive(1, 1, 1, 4'b0010, 4'b0010, 32'h200, 32'h11111111);
        expect_at(1, "t3_keep_log", 1, 1, 4'b0001, 32'h100, 32'h00B50533, 2);
        step();
        idle_inputs();
        step();
        expect_at(1, "req_held", 1, 1, 4'b0001, 32'h100, 32'h00B50533, 2);
        step();

        // ack: req drops next cycle, halt held for two drain cycles
        exc_ack_i = 1'b1;
        expect_at(1, "ack_req_drop", 0, 1, 4'b0001, 32'h100, 32'h00B50533, 2);
        step();
        exc_ack_i = 1'b0;
        // hit in DRAIN: counted, log kept, no new request
        drive(1, 1, 1, 4'b0001, 4'b0001, 32'h600, 32'h66666666);
        expect_at(1, "drain_hit", 0, 1, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();
        idle_inputs();
        expect_at(1, "drain_end", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();

        // ack outside REQ is ignored
        exc_ack_i = 1'b1;
        expect_at(1, "ack_idle", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();
        exc_ack_i = 1'b0;

        // non-violating vectors
        drive(1, 1, 1, 4'b1111, 4'b0000, 32'h900, 32'h99999999);
        expect_at(1, "no_tags", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();
        drive(0, 1, 1, 4'b1111, 4'b1111, 32'h900, 32'h99999999);
        expect_at(1, "disabled", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();
        drive(1, 1, 0, 4'b1111, 4'b1111, 32'h900, 32'h99999999);
        expect_at(1, "not_ready", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();
        drive(1, 0, 1, 4'b1111, 4'b1111, 32'h900, 32'h99999999);
        expect_at(1, "not_valid", 0, 0, 4'b0001, 32'h100, 32'h00B50533, 3);
        step();

        // mixed mask: checks {pc,d,s1}, tags {pc,d,s2} -> cause {pc,d}
        drive(1, 1, 1, 4'b1101, 4'b1110, 32'h300, 32'h22222222);
        expect_at(1, "mask_pc_d", 1, 1, 4'b1100, 32'h300, 32'h22222222, 4);
        step();
        idle_inputs();

        // saturation while held in REQ
        for (int i = 0; i < 20; i++) begin
            int e;
            e = (5 + i > 15) ? 15 : 5 + i;
            drive(1, 1, 1, 4'b0001, 4'b0001, 32'h700 + i, 32'h77777777);
            expect_at(1, $sformatf("sat_%0d", i), 1, 1, 4'b1100, 32'h300, 32'h22222222, e);
            step();
            idle_inputs();
            step();
        end

        // software clear in REQ: log/count cleared, state kept
        clr_i = 1'b1;
        expect_at(1, "clr_req", 1, 1, 4'b0000, 32'h0, 32'h0, 0);
        step();
        // clear + hit in REQ: count 1, log stays cleared
        drive(1, 1, 1, 4'b0001, 4'b0001, 32'h800, 32'h88888888);
        expect_at(1, "clr_hit_req", 1, 1, 4'b0000, 32'h0, 32'h0, 1);
        step();
        clr_i = 1'b0;
        idle_inputs();

        exc_ack_i = 1'b1;
        expect_at(1, "ack2", 0, 1, 4'b0000, 32'h0, 32'h0, 1);
        step();
        exc_ack_i = 1'b0;
        step();
        expect_at(1, "idle2", 0, 0, 4'b0000, 32'h0, 32'h0, 1);
        step();

        // clear + hit in IDLE: hit logs, count becomes 1
        clr_i = 1'b1;
        drive(1, 1, 1, 4'b0001, 4'b0001, 32'h400, 32'h33333333);
        expect_at(1, "clr_hit_idle", 1, 1, 4'b0001, 32'h400, 32'h33333333, 1);
        step();
        clr_i = 1'b0;
        idle_inputs();

        // reset while requesting
        rst = 1'b1;
        expect_at(1, "rst_mid_req", 0, 0, 4'b0000, 32'h0, 32'h0, 0);
        step();
        rst = 1'b0;

        // fresh violation after reset
        drive(1, 1, 1, 4'b0010, 4'b0010, 32'h500, 32'h44444444);
        expect_at(1, "fresh", 1, 1, 4'b0010, 32'h500, 32'h44444444, 1);
        step();
        idle_inputs();
        exc_ack_i = 1'b1;
        expect_at(1, "fresh_ack", 0, 1, 4'b0010, 32'h500, 32'h44444444, 1);
        step();
        exc_ack_i = 1'b0;
        step();
        expect_at(1, "fresh_idle", 0, 0, 4'b0010, 32'h500, 32'h44444444, 1);
        step();
        step();
        step();
        stim_done = 1'b1;
    end

    // ---------------- end of test ----------------
    initial begin
        fork
            wait (stim_done);
            #200000;
        join_any
        disable fork;
        if (!stim_done) begin
            errors++;
            $display("FAIL timeout: stimulus incomplete at cycle %0d", cyc);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
